// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM encodings,
// RV64 load/store funct3 values and the access-size helper.
package lsu_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned NBYTES = XLEN / 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Bytes touched by an access of the given size field (funct3[1:0]).
    function automatic logic [3:0] byte_count(input logic [1:0] size);
        case (size)
            2'b00:   byte_count = 4'd1;
            2'b01:   byte_count = 4'd2;
            2'b10:   byte_count = 4'd4;
            default: byte_count = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake between the execute stage (master) and the LSU (slave).
interface lsu_if;
    import lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/load_extend.sv
// Narrows a 64-bit memory word to the load size and sign/zero-extends it;
// flags the one funct3 encoding that has no load meaning.
module load_extend
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] buffer,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data_c,
    output logic            illegal_c
);

    always_comb begin
        data_c    = '0;
        illegal_c = 1'b0;
        case (funct3)
            F3_B:    data_c = {{(XLEN-8){buffer[7]}},   buffer[7:0]};
            F3_H:    data_c = {{(XLEN-16){buffer[15]}}, buffer[15:0]};
            F3_W:    data_c = {{(XLEN-32){buffer[31]}}, buffer[31:0]};
            F3_D:    data_c = buffer;
            F3_BU:   data_c = {{(XLEN-8){1'b0}},  buffer[7:0]};
            F3_HU:   data_c = {{(XLEN-16){1'b0}}, buffer[15:0]};
            F3_WU:   data_c = {{(XLEN-32){1'b0}}, buffer[31:0]};
            default: illegal_c = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer in front of an 8-byte-wide data memory; sub-word
// stores are done as read-modify-write, loads are extended on return.
module load_store_unit
    import lsu_pkg::*;
(
    input  logic            clk,
    input  logic            rstn,
    lsu_if.slave            bus,
    output logic [XLEN-1:0] mem_address,
    output logic [XLEN-1:0] mem_write_data,
    output logic            mem_write_en,
    output logic            mem_read_en,
    input  logic [XLEN-1:0] mem_read_data
);

    logic [1:0]      state_q, state_d;
    logic            write_q, write_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_err_q, resp_err_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            mem_read_en_q, mem_read_en_d;
    logic            mem_write_en_q, mem_write_en_d;
    logic [XLEN-1:0] mem_address_q, mem_address_d;
    logic [XLEN-1:0] mem_write_data_q, mem_write_data_d;

    logic [2:0]      ext_funct3_c;
    logic [XLEN-1:0] ext_data_c;
    logic            ext_illegal_c;
    logic [XLEN-1:0] merged_c;
    logic            req_illegal_c;

    // In IDLE the extender only serves as the load-legality decoder for the incoming request.
    assign ext_funct3_c = (state_q == ST_IDLE) ? bus.req_funct3 : funct3_q;

    load_extend u_load_extend (
        .buffer    (mem_read_data),
        .funct3    (ext_funct3_c),
        .data_c    (ext_data_c),
        .illegal_c (ext_illegal_c)
    );

    assign req_illegal_c = bus.req_write ? bus.req_funct3[2] : ext_illegal_c;

    // Store merge: low N bytes from store data, the rest from the word just read.
    always_comb begin
        merged_c = mem_read_data;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            if (4'(i) < byte_count(funct3_q[1:0])) begin
                merged_c[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        funct3_d         = funct3_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        resp_err_d       = resp_err_q;
        resp_rdata_d     = resp_rdata_q;
        mem_write_data_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    write_d  = bus.req_write;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    if (req_illegal_c) begin
                        state_d      = ST_RESP;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else if (bus.req_write && (bus.req_funct3 == F3_D)) begin
                        state_d          = ST_WRITE;
                        mem_write_data_d = bus.req_wdata;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (write_q) begin
                    state_d          = ST_WRITE;
                    mem_write_data_d = merged_c;
                end else begin
                    state_d      = ST_RESP;
                    resp_rdata_d = ext_data_c;
                    resp_err_d   = 1'b0;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_rdata_d = '0;
                resp_err_d   = 1'b0;
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Registered outputs are decoded from the next state so they line up with it.
        req_ready_d    = (state_d == ST_IDLE);
        resp_valid_d   = (state_d == ST_RESP);
        mem_read_en_d  = (state_d == ST_READ);
        mem_write_en_d = (state_d == ST_WRITE);
        mem_address_d  = (mem_read_en_d || mem_write_en_d) ? addr_d : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= ST_IDLE;
            write_q          <= 1'b0;
            funct3_q         <= '0;
            addr_q           <= '0;
            wdata_q          <= '0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= '0;
            mem_read_en_q    <= 1'b0;
            mem_write_en_q   <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            write_q          <= write_d;
            funct3_q         <= funct3_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_err_q       <= resp_err_d;
            resp_rdata_q     <= resp_rdata_d;
            mem_read_en_q    <= mem_read_en_d;
            mem_write_en_q   <= mem_write_en_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_err    = resp_err_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign mem_read_en     = mem_read_en_q;
    assign mem_write_en    = mem_write_en_q;
    assign mem_address     = mem_address_q;
    assign mem_write_data  = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 256-byte little-endian memory model.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic            clk;
    logic            rstn;
    logic [63:0]     mem_address;
    logic [63:0]     mem_write_data;
    logic            mem_write_en;
    logic            mem_read_en;
    logic [63:0]     mem_read_data;

    logic [7:0]      mem [256];
    int              n_vec;
    int              n_err;
    int              rd_cnt;
    int              wr_cnt;
    int              overlap;
    logic [63:0]     last_wdata;

    lsu_if bus ();

    load_store_unit dut (
        .clk            (clk),
        .rstn           (rstn),
        .bus            (bus),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mem_read_data = '0;
        for (int k = 0; k < 8; k++) begin
            mem_read_data[8*k +: 8] = mem[8'(mem_address[7:0] + 8'(k))];
        end
    end

    always @(posedge clk) begin
        if (mem_write_en) begin
            for (int k = 0; k < 8; k++) begin
                mem[8'(mem_address[7:0] + 8'(k))] <= mem_write_data[8*k +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (mem_read_en) rd_cnt++;
        if (mem_write_en) begin
            wr_cnt++;
            last_wdata = mem_write_data;
        end
        if (mem_read_en && mem_write_en) overlap++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
        end
    endtask

    // One transaction with resp_ready=1; lat counts edges from the accept edge to resp_valid.
    task automatic do_req(input logic w, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, output logic [63:0] rd,
                          output logic er, output int lat);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.resp_valid) check("resp_timeout", 64'(bus.resp_valid), 64'd1);
        rd = bus.resp_rdata;
        er = bus.resp_err;
        @(posedge clk);
        #1;
    endtask

    logic [63:0] rd;
    logic        er;
    int          lat;
    int          waited;

    initial begin
        n_vec = 0; n_err = 0; rd_cnt = 0; wr_cnt = 0; overlap = 0; last_wdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[16+i] = 8'(8'h80 + i);
        rstn = 1'b0;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;

        #12;
        check("rst_req_ready",  64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_err",   64'(bus.resp_err), 64'd0);
        check("rst_resp_rdata", bus.resp_rdata, 64'd0);
        check("rst_mem_en",     {62'd0, mem_read_en, mem_write_en}, 64'd0);
        check("rst_mem_addr",   mem_address, 64'd0);
        check("rst_mem_wdata",  mem_write_data, 64'd0);
        @(negedge clk);
        rstn = 1'b1;

        do_req(1'b0, F3_B, 64'h10, 64'd0, rd, er, lat);
        check("lb_data", rd, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_lat", 64'(lat), 64'd2);
        do_req(1'b0, F3_BU, 64'h10, 64'd0, rd, er, lat);
        check("lbu_data", rd, 64'h80);
        do_req(1'b0, F3_D, 64'h10, 64'd0, rd, er, lat);
        check("ld_data", rd, 64'h8786_8584_8382_8180);
        check("ld_lat", 64'(lat), 64'd2);

        rd_cnt = 0; wr_cnt = 0;
        do_req(1'b1, F3_B, 64'h12, 64'hAA, rd, er, lat);
        check("sb_lat", 64'(lat), 64'd3);
        check("sb_rd_cnt", 64'(rd_cnt), 64'd1);
        check("sb_wr_cnt", 64'(wr_cnt), 64'd1);
        check("sb_wdata", last_wdata, 64'h0000_8786_8584_83AA);
        check("sb_resp", {rd[62:0], er}, 64'd0);
        do_req(1'b0, F3_D, 64'h12, 64'd0, rd, er, lat);
        check("ld_after_sb", rd, 64'h0000_8786_8584_83AA);
        do_req(1'b0, F3_D, 64'h10, 64'd0, rd, er, lat);
        check("ld10_after_sb", rd, 64'h8786_8584_83AA_8180);

        rd_cnt = 0; wr_cnt = 0;
        do_req(1'b1, F3_D, 64'h20, 64'h0123_4567_89AB_CDEF, rd, er, lat);
        check("sd_lat", 64'(lat), 64'd2);
        check("sd_rd_cnt", 64'(rd_cnt), 64'd0);
        check("sd_wr_cnt", 64'(wr_cnt), 64'd1);
        check("sd_wdata", last_wdata, 64'h0123_4567_89AB_CDEF);
        do_req(1'b0, F3_W, 64'h20, 64'd0, rd, er, lat);
        check("lw_data", rd, 64'hFFFF_FFFF_89AB_CDEF);
        do_req(1'b0, F3_WU, 64'h20, 64'd0, rd, er, lat);
        check("lwu_data", rd, 64'h0000_0000_89AB_CDEF);
        do_req(1'b0, F3_H, 64'h20, 64'd0, rd, er, lat);
        check("lh_data", rd, 64'hFFFF_FFFF_FFFF_CDEF);
        do_req(1'b0, F3_HU, 64'h20, 64'd0, rd, er, lat);
        check("lhu_data", rd, 64'h0000_0000_0000_CDEF);
        do_req(1'b0, F3_D, 64'h1E, 64'd0, rd, er, lat);
        check("ld_misaligned", rd, 64'h4567_89AB_CDEF_0000);

        do_req(1'b1, F3_W, 64'h28, 64'hDEAD_BEEF_CAFE_F00D, rd, er, lat);
        do_req(1'b1, F3_H, 64'h28, 64'h0000_0000_0000_1234, rd, er, lat);
        do_req(1'b0, F3_D, 64'h28, 64'd0, rd, er, lat);
        check("ld_after_sw_sh", rd, 64'h0000_0000_CAFE_1234);
        do_req(1'b0, F3_B, 64'h2A, 64'd0, rd, er, lat);
        check("lb_neg_2a", rd, 64'hFFFF_FFFF_FFFF_FFFE);

        rd_cnt = 0; wr_cnt = 0;
        do_req(1'b0, 3'b111, 64'h10, 64'd0, rd, er, lat);
        check("ill_ld_err", 64'(er), 64'd1);
        check("ill_ld_rdata", rd, 64'd0);
        check("ill_ld_lat", 64'(lat), 64'd1);
        do_req(1'b1, F3_BU, 64'h10, 64'hFF, rd, er, lat);
        check("ill_st_err", 64'(er), 64'd1);
        check("ill_st_lat", 64'(lat), 64'd1);
        check("ill_mem_en", 64'(rd_cnt + wr_cnt), 64'd0);
        do_req(1'b0, F3_D, 64'h10, 64'd0, rd, er, lat);
        check("ld_after_ill_st", rd, 64'h8786_8584_83AA_8180);

        // Backpressure: response must hold while a second request is offered.
        bus.resp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = F3_BU;
        bus.req_addr = 64'h11; bus.req_wdata = '0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        waited = 0;
        while (!bus.resp_valid && waited < 16) begin
            @(posedge clk);
            #1;
            waited++;
        end
        rd_cnt = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_funct3 = F3_D; bus.req_addr = 64'h20;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(bus.resp_valid), 64'd1);
            check("hold_rdata", bus.resp_rdata, 64'h81);
            check("hold_req_ready", 64'(bus.req_ready), 64'd0);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("hold_no_accept", 64'(rd_cnt + 32'(bus.resp_valid)), 64'd0);

        // Reset in the WRITE cycle of an SH: write enable drops without a clock edge.
        wr_cnt = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = F3_H;
        bus.req_addr = 64'h20; bus.req_wdata = 64'h1111;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("sh_in_write", 64'(mem_write_en), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_async_we", 64'(mem_write_en), 64'd0);
        check("rst_async_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_no_resp", 64'(bus.resp_valid), 64'd0);
        check("rst_no_write", 64'(wr_cnt), 64'd0);
        do_req(1'b0, F3_D, 64'h20, 64'd0, rd, er, lat);
        check("rst_mem_intact", rd, 64'h0123_4567_89AB_CDEF);

        check("en_overlap", 64'(overlap), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
